gpsdc_trip_acc: RTL and testbench

- Downstream consumer of the GPS distance calculator's per-segment result (Valid pulse plus 40-bit distance D).
- Filters jitter segments, accumulates total trip distance, counts accepted segments and tracks the longest segment.
- Serialises a consistent snapshot of these statistics to a host over a 32-bit valid/ready read port.

---
 rtl/gpsdc_pkg.sv | 37 +++
 rtl/gpsdc_sat_add.sv | 17 +
 rtl/gpsdc_trip_acc.sv | 146 ++++++++++++++
 tb/tb_gpsdc_trip_acc.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpsdc_pkg.sv
// Shared constants, readout word map and FSM state type for the GPS trip accumulator.
package gpsdc_pkg;

  localparam int D_W       = 40;
  localparam int RD_W      = 32;
  localparam int NUM_WORDS = 5;

  localparam logic [2:0] W_TOT_LO = 3'd0;
  localparam logic [2:0] W_TOT_HI = 3'd1;
  localparam logic [2:0] W_CNT    = 3'd2;
  localparam logic [2:0] W_MAX_LO = 3'd3;
  localparam logic [2:0] W_MAX_HI = 3'd4;

  typedef enum logic {IDLE, SEND} state_t;

  // Word layout seen by the host; total and count arrive pre-extended to 56/24 bits.
  function automatic logic [RD_W-1:0] pack_word(
    input logic [2:0]     idx,
    input logic [55:0]    tot,
    input logic [23:0]    cnt,
    input logic [D_W-1:0] mx,
    input logic           sat
  );
    logic [RD_W-1:0] w;
    w = '0;
    case (idx)
      W_TOT_LO: w = tot[31:0];
      W_TOT_HI: w = {sat, 7'd0, tot[55:32]};
      W_CNT:    w = {8'd0, cnt};
      W_MAX_LO: w = mx[31:0];
      W_MAX_HI: w = {24'd0, mx[39:32]};
      default:  w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/gpsdc_sat_add.sv
// Unsigned saturating adder; ovf flags that the true sum did not fit and was pinned to all-ones.
module gpsdc_sat_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] raw;

  assign raw = {1'b0, a} + {1'b0, b};
  assign ovf = raw[W];
  assign sum = raw[W] ? {W{1'b1}} : raw[W-1:0];

endmodule

// File: rtl/gpsdc_trip_acc.sv
// Trip statistics accumulator: filters jitter segments, keeps total/count/max and
// streams a frozen snapshot to the host as five 32-bit words over valid/ready.
module gpsdc_trip_acc
  import gpsdc_pkg::*;
#(
  parameter logic [39:0] MIN_STEP = 40'd0,
  parameter int          TOT_W    = 56,
  parameter int          CNT_W    = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [39:0] in_d,
  input  logic        clear,
  input  logic        rd_req,
  input  logic        rd_ready,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_last,
  output logic        busy,
  output logic        sat_flag
);

  logic [TOT_W-1:0] total, tot_sum;
  logic [CNT_W-1:0] count, cnt_sum;
  logic [D_W-1:0]   max_d;
  logic             tot_ovf, cnt_ovf;
  logic [D_W:0]     step_diff;
  logic             accept;

  // Borrow out of in_d - MIN_STEP means the segment is below the jitter threshold.
  assign step_diff = {1'b0, in_d} - {1'b0, MIN_STEP};
  assign accept    = in_valid && !clear && !step_diff[D_W];

  gpsdc_sat_add #(.W(TOT_W)) u_tot_add (
    .a   (total),
    .b   (TOT_W'(in_d)),
    .sum (tot_sum),
    .ovf (tot_ovf)
  );

  gpsdc_sat_add #(.W(CNT_W)) u_cnt_add (
    .a   (count),
    .b   (CNT_W'(1)),
    .sum (cnt_sum),
    .ovf (cnt_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total    <= '0;
      count    <= '0;
      max_d    <= '0;
      sat_flag <= 1'b0;
    end else if (clear) begin
      total    <= '0;
      count    <= '0;
      max_d    <= '0;
      sat_flag <= 1'b0;
    end else if (accept) begin
      total <= tot_sum;
      count <= cnt_sum;
      if (in_d > max_d) max_d <= in_d;
      if (tot_ovf || cnt_ovf) sat_flag <= 1'b1;
    end
  end

  state_t         state, state_next;
  logic [2:0]     idx, idx_next;
  logic [55:0]    snap_tot, tot_ext;
  logic [23:0]    snap_cnt, cnt_ext;
  logic [D_W-1:0] snap_max;
  logic           snap_sat;
  logic           snap_load;
  logic           valid_next, last_next;
  logic [31:0]    data_next;

  assign tot_ext = 56'(total);
  assign cnt_ext = 24'(count);
  assign busy    = (state == SEND);

  always_comb begin
    state_next = state;
    idx_next   = idx;
    snap_load  = 1'b0;
    valid_next = rd_valid;
    data_next  = rd_data;
    last_next  = rd_last;
    case (state)
      IDLE: begin
        if (rd_req) begin
          // Word 0 comes from the live stats, which equal what the snapshot captures.
          snap_load  = 1'b1;
          state_next = SEND;
          idx_next   = W_TOT_LO;
          valid_next = 1'b1;
          data_next  = pack_word(W_TOT_LO, tot_ext, cnt_ext, max_d, sat_flag);
          last_next  = 1'b0;
        end
      end
      SEND: begin
        if (rd_ready) begin
          if (idx == 3'(NUM_WORDS - 1)) begin
            state_next = IDLE;
            idx_next   = '0;
            valid_next = 1'b0;
            data_next  = '0;
            last_next  = 1'b0;
          end else begin
            idx_next  = idx + 3'd1;
            data_next = pack_word(idx + 3'd1, snap_tot, snap_cnt, snap_max, snap_sat);
            last_next = ((idx + 3'd1) == W_MAX_HI);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
      snap_tot <= '0;
      snap_cnt <= '0;
      snap_max <= '0;
      snap_sat <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      rd_valid <= valid_next;
      rd_data  <= data_next;
      rd_last  <= last_next;
      if (snap_load) begin
        snap_tot <= tot_ext;
        snap_cnt <= cnt_ext;
        snap_max <= max_d;
        snap_sat <= sat_flag;
      end
    end
  end

endmodule

// File: tb/tb_gpsdc_trip_acc.sv
// Bench: three accumulator variants driven in lockstep and checked against a queue-based statistics model.
module tb_gpsdc_trip_acc;

  localparam int N = 3;

  logic        clk;
  logic        reset, in_valid, clear, rd_req, rd_ready;
  logic [39:0] in_d;
  logic        rd_valid [N];
  logic [31:0] rd_data  [N];
  logic        rd_last  [N];
  logic        busy     [N];
  logic        sat_flag [N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gpsdc_trip_acc u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_d(in_d), .clear(clear),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
    .rd_last(rd_last[0]), .busy(busy[0]), .sat_flag(sat_flag[0])
  );

  gpsdc_trip_acc #(.MIN_STEP(40'd500)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_d(in_d), .clear(clear),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
    .rd_last(rd_last[1]), .busy(busy[1]), .sat_flag(sat_flag[1])
  );

  // Narrow accumulators so saturation is reachable in a few dozen samples.
  gpsdc_trip_acc #(.TOT_W(44), .CNT_W(4)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_d(in_d), .clear(clear),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_valid(rd_valid[2]), .rd_data(rd_data[2]),
    .rd_last(rd_last[2]), .busy(busy[2]), .sat_flag(sat_flag[2])
  );

  logic [63:0] m_tot [N];
  logic [63:0] m_cnt [N];
  logic [63:0] m_max [N];
  logic        m_sat [N];
  logic [63:0] min_step [N];
  logic [63:0] tot_max  [N];
  logic [63:0] cnt_max  [N];
  logic [31:0] exp_q [N][$];
  logic [31:0] cap [$];
  logic [31:0] want [5];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input int i, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, i, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i, input int k);
    logic [63:0] t, c, m;
    t = m_tot[i];
    c = m_cnt[i];
    m = m_max[i];
    case (k)
      0:       return t[31:0];
      1:       return {m_sat[i], 7'd0, t[55:32]};
      2:       return {8'd0, c[23:0]};
      3:       return m[31:0];
      default: return {24'd0, m[39:32]};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_tot[i] = 0;
      m_cnt[i] = 0;
      m_max[i] = 0;
      m_sat[i] = 1'b0;
      exp_q[i].delete();
    end
  endtask

  task automatic model_edge();
    logic        was_busy;
    logic [63:0] d;
    if (reset) begin
      model_reset();
      return;
    end
    was_busy = (exp_q[0].size() != 0);
    d = {24'd0, in_d};
    for (int i = 0; i < N; i++) begin
      if (was_busy && rd_ready) void'(exp_q[i].pop_front());
      if (!was_busy && rd_req)
        for (int k = 0; k < 5; k++) exp_q[i].push_back(word_of(i, k));
      if (clear) begin
        m_tot[i] = 0;
        m_cnt[i] = 0;
        m_max[i] = 0;
        m_sat[i] = 1'b0;
      end else if (in_valid && d >= min_step[i]) begin
        if (m_tot[i] + d > tot_max[i]) begin
          m_tot[i] = tot_max[i];
          m_sat[i] = 1'b1;
        end else m_tot[i] = m_tot[i] + d;
        if (m_cnt[i] + 1 > cnt_max[i]) begin
          m_cnt[i] = cnt_max[i];
          m_sat[i] = 1'b1;
        end else m_cnt[i] = m_cnt[i] + 1;
        if (d > m_max[i]) m_max[i] = d;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk("rd_valid", i, 64'(rd_valid[i]), 64'(exp_q[i].size() != 0));
      chk("busy", i, 64'(busy[i]), 64'(exp_q[i].size() != 0));
      chk("sat_flag", i, 64'(sat_flag[i]), 64'(m_sat[i]));
      if (exp_q[i].size() != 0) begin
        chk("rd_data", i, 64'(rd_data[i]), 64'(exp_q[i][0]));
        chk("rd_last", i, 64'(rd_last[i]), 64'(exp_q[i].size() == 1));
      end
    end
  endtask

  task automatic step();
    if (rd_valid[0] && rd_ready) cap.push_back(rd_data[0]);
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic send(input logic [39:0] d);
    in_valid = 1'b1;
    in_d     = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic readout();
    cap.delete();
    rd_ready = 1'b1;
    rd_req   = 1'b1;
    step();
    rd_req = 1'b0;
    for (int c = 0; c < 20 && busy[0]; c++) step();
    chk("words_done", 0, 64'(busy[0]), 64'd0);
    chk("n_words", 0, 64'(cap.size()), 64'd5);
  endtask

  task automatic check_cap(input string tag);
    for (int k = 0; k < 5; k++)
      if (k < cap.size()) chk(tag, k, 64'(cap[k]), 64'(want[k]));
  endtask

  initial begin
    min_step = '{64'd0, 64'd500, 64'd0};
    tot_max  = '{(64'd1 << 56) - 1, (64'd1 << 56) - 1, (64'd1 << 44) - 1};
    cnt_max  = '{(64'd1 << 24) - 1, (64'd1 << 24) - 1, 64'd15};
    reset = 1'b1; in_valid = 1'b0; in_d = '0; clear = 1'b0; rd_req = 1'b0; rd_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();
    for (int i = 0; i < N; i++) chk("reset_data", i, 64'(rd_data[i]), 64'd0);

    // Basic accumulation and readout
    send(40'd1000); send(40'd2500); send(40'd400);
    readout();
    want = '{32'd3900, 32'd0, 32'd3, 32'd2500, 32'd0};
    check_cap("first_readout");

    // Jitter threshold (unit 1 drops 400)
    clear = 1'b1; step(); clear = 1'b0;
    send(40'd400); send(40'd600);
    readout();
    want = '{32'd1000, 32'd0, 32'd2, 32'd600, 32'd0};
    check_cap("after_clear");

    // Saturation on the narrow unit
    for (int k = 0; k < 20; k++) send(40'hFF_FFFF_FFFF);
    chk("sat_narrow", 2, 64'(sat_flag[2]), 64'd1);
    chk("sat_wide", 0, 64'(sat_flag[0]), 64'd0);
    readout();
    clear = 1'b1; step(); clear = 1'b0;
    chk("sat_cleared", 2, 64'(sat_flag[2]), 64'd0);
    readout();
    want = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    check_cap("cleared_stats");

    // Request coincident with a sample: snapshot excludes it
    in_valid = 1'b1; in_d = 40'd77; rd_req = 1'b1;
    cap.delete();
    step();
    in_valid = 1'b0; rd_req = 1'b0;
    for (int c = 0; c < 20 && busy[0]; c++) step();
    chk("excl_w0", 0, 64'(cap[0]), 64'd0);
    readout();
    want = '{32'd77, 32'd0, 32'd1, 32'd77, 32'd0};
    check_cap("incl_77");

    // Backpressure on word 2 with an ignored mid-readout request
    cap.delete();
    rd_req = 1'b1; step(); rd_req = 1'b0;
    step(); step();
    chk("hold_word", 0, 64'(rd_data[0]), 64'd1);
    rd_ready = 1'b0;
    step();
    rd_req = 1'b1; step(); rd_req = 1'b0;
    step();
    chk("held_word", 0, 64'(rd_data[0]), 64'd1);
    rd_ready = 1'b1;
    for (int c = 0; c < 20 && busy[0]; c++) step();
    chk("bp_words", 0, 64'(cap.size()), 64'd5);
    step();
    chk("bp_idle", 0, 64'(busy[0]), 64'd0);

    // Clear wins over a same-cycle sample
    in_valid = 1'b1; in_d = 40'd12345; clear = 1'b1;
    step();
    in_valid = 1'b0; clear = 1'b0;
    readout();
    want = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    check_cap("clear_wins");

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom % 2) == 0;
      if (($urandom % 4) == 0) in_d = 40'($urandom % 1000);
      else in_d = {8'($urandom), 32'($urandom)};
      clear    = ($urandom % 60) == 0;
      rd_req   = ($urandom % 8) == 0;
      rd_ready = ($urandom % 3) != 0;
      step();
    end
    in_valid = 1'b0; clear = 1'b0; rd_req = 1'b0; rd_ready = 1'b1;
    for (int c = 0; c < 20 && busy[0]; c++) step();

    // Reset in the middle of a readout
    rd_req = 1'b1; step(); rd_req = 1'b0;
    rd_ready = 1'b0; step();
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_valid", i, 64'(rd_valid[i]), 64'd0);
      chk("rst_busy", i, 64'(busy[i]), 64'd0);
      chk("rst_last", i, 64'(rd_last[i]), 64'd0);
      chk("rst_data", i, 64'(rd_data[i]), 64'd0);
    end
    model_reset();
    step();
    reset = 1'b0; rd_ready = 1'b1;
    step();
    readout();
    want = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    check_cap("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
